fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Multi-cycle sequencer between the instruction memory (IM) and the datapath in top.
//  Owns the PC and drives the IM control strobes.
//  Latches each fetched word into an instruction register (IR).
//  Emits one-hot phase enables (decode/execute/writeback) so every instruction takes exactly 4 cycles.
// PARAMETERS
//  DataSize  32            instruction / IR width
//  MemSize   10            PC (IM address) width
//  NOP_WORD  32'h6400_0009 encoding that suppresses register writeback
// PORTS
//  clk          in   1         clock, rising edge
//  reset        in   1         asynchronous, active-low reset
//  instruction  in   DataSize  IMout, valid the cycle after a fetch strobe
//  stall        in   1         hold in EXECUTE while high
//  halt         in   1         stop after the current instruction retires
//  PC           out  MemSize   IM address
//  IM_read      out  1         IM enable_fetch
//  IM_write     out  1         IM enable_write, constant 0
//  IM_enable    out  1         IM enable_im
//  ir           out  DataSize  instruction register
//  decode_en    out  1         high in DECODE
//  exec_en      out  1         high in EXECUTE
//  wb_en        out  1         regfile write enable, high in WRITEBACK when ir != NOP_WORD
//  halted       out  1         high in HALT
//  instr_cnt    out  16        retired-instruction counter
// BEHAVIOUR
//  Reset
//  - reset low (async): state=IDLE; PC=0, ir=0, instr_cnt=0.
//  - Same reset (async): all strobes/enables low, halted=0.
//  - Applies immediately, mid-instruction included; the partial instruction is discarded.
//  States: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH | HALT
//  - IDLE: exactly 1 cycle after reset deasserts, then FETCH.
//  - FETCH: IM_read=1, IM_enable=1, PC stable; IM registers the word at the closing edge.
//  - DECODE: decode_en=1; ir <= instruction at the closing edge.
//  - EXECUTE: exec_en=1; stays while stall=1, leaves on the first edge with stall=0.
//  - WRITEBACK: wb_en=(ir!=NOP_WORD).
//  - WRITEBACK closing edge: PC<=PC+1 (wraps 2^MemSize-1 -> 0), instr_cnt<=instr_cnt+1 (wraps at 16'hFFFF).
//  - WRITEBACK closing edge: next=HALT if halt=1 sampled there, else FETCH.
//  - HALT: halted=1, all strobes/enables 0, PC/ir/instr_cnt frozen; exit only via reset.
//  Latency / timing
//  - Unstalled instruction = 4 cycles; first fetch strobe on the 2nd rising edge after reset release.
//  Inputs and outputs
//  - halt is ignored in every state except WRITEBACK; stall is ignored outside EXECUTE.
//  - halt and stall both high in EXECUTE: stall wins; halt is re-sampled in WRITEBACK.
//  - All outputs are registered or decoded from the state register only, with no combinational input->output path.
//  - PC changes only on the WRITEBACK closing edge.
//  - IM_write is never asserted.
// TESTING
//  1. Reset deasserted with IM[0..2]=MOVI R0,4 / ADDI R0,R0,13 / ORI R1,R0,2.
//     -> IM_read pulses every 4 cycles; PC=0,1,2 on the pulses.
//     -> Regfile reg_0=32'h04 then 32'h11; reg_1=32'h13.
//  2. IM[1]=32'h6400_0009 (NOP) -> wb_en stays 0 for that instruction; reg_0..reg_9 unchanged; instr_cnt still increments.
//  3. stall high for 3 cycles in EXECUTE of instr 0.
//     -> That instruction takes 7 cycles; PC=1 exactly 7 cycles after the first fetch; no extra wb_en pulse.
//  4. halt raised in EXECUTE and held through WRITEBACK of instr 2 -> halted=1; PC=3, instr_cnt=3, IM_read=0 thereafter.
//  5. reset pulsed low mid-DECODE -> all outputs 0 at once.
//     -> After release, IDLE then FETCH at PC=0; ir reloads IM[0].
//  6. MemSize=2 with 5 instructions retired -> PC sequence 0,1,2,3,0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer.
// Owns the PC, drives the instruction-memory strobes and holds the instruction register.
module fetch_ctrl #(
    parameter int                   DataSize = 32,
    parameter int                   MemSize  = 10,
    parameter logic [DataSize-1:0]  NOP_WORD = 32'h6400_0009
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DataSize-1:0] instruction,
    input  logic                stall,
    input  logic                halt,
    output logic [MemSize-1:0]  PC,
    output logic                IM_read,
    output logic                IM_write,
    output logic                IM_enable,
    output logic [DataSize-1:0] ir,
    output logic                decode_en,
    output logic                exec_en,
    output logic                wb_en,
    output logic                halted,
    output logic [15:0]         instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Every output is a decode of the state register (plus ir), so no input reaches an output combinationally.
    always_comb begin
        next_state = state;
        IM_read    = 1'b0;
        IM_enable  = 1'b0;
        decode_en  = 1'b0;
        exec_en    = 1'b0;
        wb_en      = 1'b0;
        halted     = 1'b0;
        case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                IM_read    = 1'b1;
                IM_enable  = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                decode_en  = 1'b1;
                next_state = S_EXECUTE;
            end
            S_EXECUTE: begin
                exec_en = 1'b1;
                if (!stall) begin
                    next_state = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                wb_en      = (ir != NOP_WORD);
                next_state = halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign IM_write = 1'b0;

    // The IM word is valid during DECODE; PC and the retire count advance only as WRITEBACK closes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC        <= '0;
            ir        <= '0;
            instr_cnt <= '0;
        end else begin
            if (state == S_DECODE) begin
                ir <= instruction;
            end
            if (state == S_WRITEBACK) begin
                PC        <= PC + MemSize'(1);
                instr_cnt <= instr_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: instruction sequencing, NOP writeback suppression,
// stall, halt, mid-instruction reset and PC wraparound on a narrow instance.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP_WORD = 32'h6400_0009;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        halt;
    logic [31:0] instruction = '0;
    logic [9:0]  PC;
    logic        IM_read, IM_write, IM_enable;
    logic [31:0] ir;
    logic        decode_en, exec_en, wb_en, halted;
    logic [15:0] instr_cnt;

    logic        reset2;
    logic        stall2 = 1'b0;
    logic        halt2 = 1'b0;
    logic [31:0] instruction2 = 32'h1111_0000;
    logic [1:0]  pc2;
    logic        im_read2, im_write2, im_enable2;
    logic [31:0] ir2;
    logic        decode_en2, exec_en2, wb_en2, halted2;
    logic [15:0] instr_cnt2;

    logic [31:0] im_mem [0:15];

    int assert_cnt = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .instruction(instruction), .stall(stall), .halt(halt),
        .PC(PC), .IM_read(IM_read), .IM_write(IM_write), .IM_enable(IM_enable), .ir(ir),
        .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en), .halted(halted),
        .instr_cnt(instr_cnt)
    );

    fetch_ctrl #(.MemSize(2)) dut2 (
        .clk(clk), .reset(reset2), .instruction(instruction2), .stall(stall2), .halt(halt2),
        .PC(pc2), .IM_read(im_read2), .IM_write(im_write2), .IM_enable(im_enable2), .ir(ir2),
        .decode_en(decode_en2), .exec_en(exec_en2), .wb_en(wb_en2), .halted(halted2),
        .instr_cnt(instr_cnt2)
    );

    // Registered instruction memory: word appears the cycle after the fetch strobe.
    always @(posedge clk) begin
        if (IM_enable && IM_read) begin
            instruction <= im_mem[PC[3:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllQuiet(input string tag);
        checkOutput({tag, " PC"}, 32'(PC), 32'd0);
        checkOutput({tag, " ir"}, ir, 32'd0);
        checkOutput({tag, " instr_cnt"}, 32'(instr_cnt), 32'd0);
        checkOutput({tag, " IM_read"}, 32'(IM_read), 32'd0);
        checkOutput({tag, " IM_enable"}, 32'(IM_enable), 32'd0);
        checkOutput({tag, " IM_write"}, 32'(IM_write), 32'd0);
        checkOutput({tag, " decode_en"}, 32'(decode_en), 32'd0);
        checkOutput({tag, " exec_en"}, 32'(exec_en), 32'd0);
        checkOutput({tag, " wb_en"}, 32'(wb_en), 32'd0);
        checkOutput({tag, " halted"}, 32'(halted), 32'd0);
    endtask

    // Walks one instruction starting just after the edge that entered FETCH.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] word, input logic exp_wb,
                                 input int stall_cycles, input bit halt_at_end, input bit halt_glitch,
                                 input logic [31:0] cnt_before);
        checkOutput("fetch IM_read", 32'(IM_read), 32'd1);
        checkOutput("fetch IM_enable", 32'(IM_enable), 32'd1);
        checkOutput("fetch IM_write", 32'(IM_write), 32'd0);
        checkOutput("fetch wb_en", 32'(wb_en), 32'd0);
        checkOutput("fetch PC", 32'(PC), pc);
        checkOutput("fetch instr_cnt", 32'(instr_cnt), cnt_before);
        if (halt_glitch) halt = 1'b1;
        step();
        checkOutput("decode_en", 32'(decode_en), 32'd1);
        checkOutput("decode IM_read", 32'(IM_read), 32'd0);
        step();
        if (halt_glitch) halt = 1'b0;
        checkOutput("exec_en", 32'(exec_en), 32'd1);
        checkOutput("exec ir", ir, word);
        if (halt_at_end) halt = 1'b1;
        for (int i = 0; i < stall_cycles; i++) begin
            stall = 1'b1;
            step();
            checkOutput("stall exec_en", 32'(exec_en), 32'd1);
            checkOutput("stall wb_en", 32'(wb_en), 32'd0);
            checkOutput("stall PC", 32'(PC), pc);
        end
        stall = 1'b0;
        step();
        checkOutput("wb wb_en", 32'(wb_en), 32'(exp_wb));
        checkOutput("wb exec_en", 32'(exec_en), 32'd0);
        checkOutput("wb PC", 32'(PC), pc);
        step();
        if (halt_at_end) begin
            checkOutput("halt halted", 32'(halted), 32'd1);
            checkOutput("halt PC", 32'(PC), pc + 32'd1);
            checkOutput("halt instr_cnt", 32'(instr_cnt), cnt_before + 32'd1);
            checkOutput("halt IM_read", 32'(IM_read), 32'd0);
        end
    endtask

    initial begin
        logic [1:0] pc_seq [5];
        int k;
        pc_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        for (int i = 0; i < 16; i++) im_mem[i] = 32'h0000_0100 + 32'(i);
        im_mem[0] = 32'hA000_0004;
        im_mem[1] = 32'hA100_000D;
        im_mem[2] = 32'hA200_0002;
        im_mem[3] = NOP_WORD;

        reset = 1'b0;
        reset2 = 1'b0;
        stall = 1'b0;
        halt = 1'b0;
        #12;
        checkAllQuiet("reset");

        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("idle IM_read", 32'(IM_read), 32'd0);
        step();

        applyStimulus(32'd0, im_mem[0], 1'b1, 0, 1'b0, 1'b0, 32'd0);
        applyStimulus(32'd1, im_mem[1], 1'b1, 0, 1'b0, 1'b1, 32'd1);
        applyStimulus(32'd2, im_mem[2], 1'b1, 0, 1'b0, 1'b0, 32'd2);
        applyStimulus(32'd3, NOP_WORD, 1'b0, 0, 1'b0, 1'b0, 32'd3);
        applyStimulus(32'd4, im_mem[4], 1'b1, 0, 1'b0, 1'b0, 32'd4);

        // Reset asserted between edges while in DECODE must clear everything at once.
        step();
        checkOutput("pre-reset decode_en", 32'(decode_en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkAllQuiet("mid-decode reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("re-idle IM_read", 32'(IM_read), 32'd0);
        step();

        applyStimulus(32'd0, im_mem[0], 1'b1, 3, 1'b0, 1'b0, 32'd0);
        applyStimulus(32'd1, im_mem[1], 1'b1, 0, 1'b0, 1'b0, 32'd1);
        applyStimulus(32'd2, im_mem[2], 1'b1, 0, 1'b1, 1'b0, 32'd2);

        repeat (5) step();
        checkOutput("frozen halted", 32'(halted), 32'd1);
        checkOutput("frozen PC", 32'(PC), 32'd3);
        checkOutput("frozen instr_cnt", 32'(instr_cnt), 32'd3);
        checkOutput("frozen IM_read", 32'(IM_read), 32'd0);
        checkOutput("frozen ir", ir, im_mem[2]);
        halt = 1'b0;

        // Narrow PC instance wraps 3 -> 0.
        @(negedge clk);
        reset2 = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            step();
            if (im_read2) begin
                checkOutput("wrap PC", 32'(pc2), 32'(pc_seq[k]));
                checkOutput("wrap instr_cnt", 32'(instr_cnt2), 32'(k));
                k++;
            end
        end
        checkOutput("wrap fetch count", 32'(k), 32'd5);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
